// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store unit in front of dmem.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_READ,
    ST_WRITE,
    ST_RESP,
    ST_ERR
  } lsu_state_t;

  // Little-endian byte lanes touched by an access of the given size.
  function automatic logic [3:0] byte_mask(input size_t size, input logic [1:0] addr);
    case (size)
      SZ_BYTE: byte_mask = 4'b0001 << addr;
      SZ_HALF: byte_mask = addr[1] ? 4'b1100 : 4'b0011;
      default: byte_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input size_t size, input logic [1:0] addr);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr[0];
      SZ_WORD: misaligned = (addr != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extract/extend for loads and lane merge for sub-word stores.
// Lane layout assumes a 32-bit word (four byte lanes).
module lsu_align
  import lsu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] word,
  input  logic [N-1:0] wdata,
  input  size_t        size,
  input  logic [1:0]   addr_lo,
  input  logic         is_unsigned,
  output logic [N-1:0] load_data,
  output logic [N-1:0] merged
);

  logic [3:0]   mask;
  logic [N-1:0] lane_data;
  logic [7:0]   byte_sel;
  logic [15:0]  half_sel;

  always_comb begin
    mask     = byte_mask(size, addr_lo);
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    half_sel = word[{addr_lo[1], 4'b0000} +: 16];

    case (size)
      SZ_BYTE: lane_data = {(N/8){wdata[7:0]}};
      SZ_HALF: lane_data = {(N/16){wdata[15:0]}};
      default: lane_data = wdata;
    endcase

    merged = word;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) merged[8*i +: 8] = lane_data[8*i +: 8];
    end

    case (size)
      SZ_BYTE: load_data = is_unsigned ? {{(N-8){1'b0}}, byte_sel}
                                       : {{(N-8){byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = is_unsigned ? {{(N-16){1'b0}}, half_sel}
                                       : {{(N-16){half_sel[15]}}, half_sel};
      default: load_data = word;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_if.sv
// Load/store unit feeding a word-wide dmem; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned requests; otherwise they are force-aligned.
//
// state    | meaning
// ST_IDLE  | waiting for a request, req_ready high
// ST_LOAD  | dmem read, extended load data captured
// ST_READ  | old word captured for a sub-word store
// ST_WRITE | merged word written to dmem
// ST_RESP  | completion pulse
// ST_ERR   | misaligned completion pulse with resp_err
module lsu_dmem_if
  import lsu_pkg::*;
#(
  parameter int N = 32,
  parameter int R = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [1:0]   req_size,
  input  logic         req_unsigned,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  output logic [N-1:0] resp_rdata,
  output logic         resp_err,
  output logic [N-1:0] dmem_addr,
  output logic         dmem_we,
  output logic [N-1:0] dmem_wdata,
  input  logic [N-1:0] dmem_rdata
);

  lsu_state_t   state;
  logic         we_q;
  size_t        size_q;
  logic         uns_q;
  logic [R+1:0] addr_q;
  logic [N-1:0] wdata_q;
  logic [N-1:0] old_q;
  logic [N-1:0] rdata_q;

  size_t        size_n;
  logic [R+1:0] addr_n;
  lsu_state_t   accept_state;
  logic [N-1:0] align_word;
  logic [N-1:0] load_data;
  logic [N-1:0] merged;
  logic         unused_addr_hi;

  assign unused_addr_hi = ^req_addr[N-1:R+2];

  always_comb begin
    size_n = size_t'(req_size);
    addr_n = req_addr[R+1:0];
`ifdef LSU_MISALIGN_TRAP_EN
`else
    if (size_n == SZ_ILL) size_n = SZ_WORD;
    if (size_n == SZ_HALF) addr_n[0] = 1'b0;
    else if (size_n == SZ_WORD) addr_n[1:0] = 2'b00;
`endif
  end

  always_comb begin
    if (!req_we) accept_state = ST_LOAD;
    else if (size_n == SZ_WORD) accept_state = ST_WRITE;
    else accept_state = ST_READ;
`ifdef LSU_MISALIGN_TRAP_EN
    if (misaligned(size_n, addr_n[1:0])) accept_state = ST_ERR;
`endif
  end

  // Loads align the live dmem word; stores merge into the word captured in READ.
  assign align_word = (state == ST_LOAD) ? dmem_rdata : old_q;

  lsu_align #(.N(N)) u_align (
    .word        (align_word),
    .wdata       (wdata_q),
    .size        (size_q),
    .addr_lo     (addr_q[1:0]),
    .is_unsigned (uns_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= size_n;
            uns_q   <= req_unsigned;
            addr_q  <= addr_n;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            state   <= accept_state;
          end
        end
        ST_LOAD: begin
          rdata_q <= load_data;
          state   <= ST_RESP;
        end
        ST_READ: begin
          old_q <= dmem_rdata;
          state <= ST_WRITE;
        end
        ST_WRITE: state <= ST_RESP;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP) || (state == ST_ERR);
  assign resp_rdata = (state == ST_RESP && !we_q) ? rdata_q : '0;
  assign dmem_we    = (state == ST_WRITE) && rst_n;
  assign dmem_wdata = (state == ST_WRITE) ? merged : '0;
  assign dmem_addr  = (state == ST_LOAD || state == ST_READ || state == ST_WRITE)
                      ? {{(N-R){1'b0}}, addr_q[R+1:2]} : '0;

`ifdef LSU_MISALIGN_TRAP_EN
  assign resp_err = (state == ST_ERR);
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: doc/lsu_dmem_if.md
Name: lsu_dmem_if

Overview:
Load/store unit directly upstream of dmem. It accepts one memory request at a time from the datapath and handles byte, halfword and word accesses. Loads are sign- or zero-extended. Sub-word stores are done as read-modify-write, because dmem has only a word-wide write_enable. It converts byte addresses to the word index dmem expects.

Parameters:
N, 32, data/address width in bits
R, 6, dmem word-index width (2**R words)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_we  input  1  1=store, 0=load
req_size  input  2  00=byte, 01=half, 10=word, 11=illegal (treated as misaligned)
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
req_addr  input  N  byte address
req_wdata  input  N  store data; valid bits are in the LSBs
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  N  extended load data; 0 for stores and errors
resp_err  output  1  misaligned/illegal request; qualified by resp_valid
dmem_addr  output  N  word index = {0, req_addr[R+1:2]}
dmem_we  output  1  to dmem.write_enable
dmem_wdata  output  N  to dmem.writedata
dmem_rdata  input  N  from dmem.readdata (combinational read)

Behaviour:
- Reset: clk and rst_n are decided as one clock with a synchronous, active-low reset.
  - On any rising edge with rst_n=0: state=IDLE, all latched request fields=0.
  - Outputs after reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, dmem_addr=0, dmem_we=0, dmem_wdata=0.
- dmem_we is defined as (state==WRITE) && rst_n. A reset sampled during WRITE therefore never commits the write.
- Handshake: a request is accepted on an edge where req_valid && req_ready. All request fields are latched at that edge. The response has no backpressure.
- Misalignment rules:
  - half with addr[0]=1 is misaligned.
  - word with addr[1:0]!=0 is misaligned.
  - size=11 is always misaligned.
- FSM states: IDLE, LOAD, READ, WRITE, RESP, ERR.
- Transitions from IDLE on accept:
  - misaligned → ERR
  - load → LOAD
  - word store → WRITE
  - byte/half store → READ
- LOAD → RESP. Extended data is captured from dmem_rdata at the LOAD edge.
- READ → WRITE. The old word is captured from dmem_rdata.
- WRITE → RESP.
- ERR → IDLE, with resp_valid=1 and resp_err=1 during ERR.
- RESP → IDLE, with resp_valid=1 during RESP.
- Latency from the accept edge to resp_valid high:
  - misaligned: 1 cycle
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- Merge on sub-word store:
  - byte lane = addr[1:0]; half lane = addr[1].
  - Lanes are little-endian (lane 0 = bits 7:0).
  - Only the selected lane is replaced with req_wdata[7:0] or [15:0]; other bytes are kept.
- Load extraction uses the same lanes. The selected lane is extended to N bits by bit 7 or bit 15 unless req_unsigned=1.
- dmem_addr is driven from the latched address in LOAD, READ and WRITE, and is 0 otherwise.
- Address bits above R+1 are ignored; the word index wraps modulo 2**R.
- dmem_wdata is valid only in WRITE and is 0 otherwise.
- A req_valid arriving while busy is ignored (req_ready=0). The requester holds it until accepted.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: behaviour is as above; misaligned requests go to ERR and memory is never touched.
- Undefined:
  - The ERR state is not built and resp_err is tied to 0.
  - Misaligned addresses are force-aligned: half clears addr[0], word clears addr[1:0].
  - size=11 is treated as word.

Decomposition:
- Package lsu_pkg holds:
  - enum size_t {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL}
  - enum lsu_state_t
  - constant lane-mask function byte_mask(size, addr[1:0])
- One sub-module, lsu_align: combinational lane extract/extend for loads and merge for stores. It is shared by the LOAD and READ/WRITE paths.

Test Plan:
- Word store at addr 0x08 with 0xDEADBEEF → dmem_we high exactly one cycle with dmem_addr=2; resp_valid 2 cycles after accept; a following word load at 0x08 returns 0xDEADBEEF.
- Mem[1]=0x11223344, byte store 0xAA at addr 0x06 → READ then WRITE; mem[1]=0x11AA3344; resp_valid 3 cycles after accept.
- Mem[0]=0x0000FF80: byte load at 0x00 signed → 0xFFFFFF80; unsigned → 0x00000080; half load at 0x00 signed → 0xFFFFFF80.
- Half load at addr 0x03 (macro on) → resp_valid and resp_err 1 cycle after accept, dmem_we never asserted; with macro off it reads the half at 0x02.
- rst_n low during the WRITE cycle of a sub-word store → dmem_we=0, memory unchanged, next cycle req_ready=1 with resp_valid=0.
- Back-to-back requests with req_valid held high → second accept only in the cycle after RESP; req_ready=0 throughout LOAD/READ/WRITE/RESP.
